// File: rtl/grf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// GrfWrArbiter (module grf_wr_arbiter)
//
// Purpose:
//   Arbitrates the single register-file write port between the W-stage
//   pipeline write and results returning from the multiply/divide unit (MDU).
//   Pipeline writes always win. MDU results wait in a 2-entry FIFO and drain
//   into idle write slots. A per-register busy scoreboard stalls D-stage
//   instructions that touch a register with an MDU result still outstanding.
//   An age counter forces a stall when the FIFO head has waited too long, so
//   the pipeline eventually produces a write-free slot for the MDU.
//
// Parameters:
//   STARVE_LIMIT  cycles the FIFO head may wait before a forced stall (def 4)
//
// Ports:
//   clk                 clock, rising edge
//   reset               synchronous, active-high reset
//   pipe_we/a3/wd/pc    W-stage write request (never back-pressured)
//   mdu_issue, mdu_dst  MDU op with a GPR destination leaves D this cycle
//   mdu_valid           MDU result offered
//   mdu_ready           MDU result accepted on this edge when mdu_valid=1
//   mdu_a3/wd/pc        MDU result destination, data and PC
//   rd_a1/a2/a3         D-stage source and destination registers
//   stall               freeze F/D and inject a bubble
//   grf_we/a3/wd/pc     registered register-file write port (1-cycle latency)
//
// Optional feature:
//   GRF_ARB_TRACE_EN    when defined, prints every granted write in simulation
//                       as "<time>@<pc hex>: $<reg> <= <data hex>".
// ---------------------------------------------------------------------------
module grf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_dst,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_a3,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    input  logic [4:0]  rd_a3,
    output logic        stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    // The age counter saturates at STARVE_LIMIT, so it only needs enough bits
    // to hold that value.
    localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    // MDU result FIFO storage and bookkeeping
    logic [4:0]       r_fifo_a3 [2];
    logic [31:0]      r_fifo_wd [2];
    logic [31:0]      r_fifo_pc [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    // Starvation tracking and register scoreboard
    logic [AGE_W-1:0] r_age;
    logic [31:0]      r_busy;

    // Registered write port
    logic             r_grf_we;
    logic [4:0]       r_grf_a3;
    logic [31:0]      r_grf_wd;
    logic [31:0]      r_grf_pc;

    // Decision wires
    logic             w_pipe_present;
    logic             w_fifo_nonempty;
    logic             w_push;
    logic             w_pop;
    logic             w_grant;
    logic [4:0]       w_head_a3;
    logic [4:0]       w_next_a3;
    logic [31:0]      w_next_wd;
    logic [31:0]      w_next_pc;
    logic [31:0]      w_busy_next;
    logic             w_starve;

    // A write to $0 is architecturally a no-op, so it must not steal the
    // port from a waiting MDU result.
    assign w_pipe_present  = pipe_we && (pipe_a3 != 5'd0);
    assign w_fifo_nonempty = (r_count != 2'd0);

    // Ready depends only on the FIFO occupancy, never on mdu_valid, which
    // keeps the handshake free of combinational loops through the MDU.
    assign mdu_ready = (r_count != 2'd2);
    assign w_push    = mdu_valid && mdu_ready;
    assign w_pop     = w_fifo_nonempty && !w_pipe_present;
    assign w_grant   = w_pipe_present || w_pop;
    assign w_head_a3 = r_fifo_a3[r_rd_ptr];

    // Select the write that will appear on the port after the next edge:
    // the pipeline write if there is one, otherwise the FIFO head.
    always_comb begin
        w_next_a3 = r_fifo_a3[r_rd_ptr];
        w_next_wd = r_fifo_wd[r_rd_ptr];
        w_next_pc = r_fifo_pc[r_rd_ptr];
        if (w_pipe_present) begin
            w_next_a3 = pipe_a3;
            w_next_wd = pipe_wd;
            w_next_pc = pipe_pc;
        end
    end

    // Scoreboard update. The clear is applied before the set so that an MDU
    // op issuing to the same register whose older result drains this edge
    // keeps that register busy for the new op. Bit 0 is forced low.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head_a3] = 1'b0;
        end
        if (mdu_issue && (mdu_dst != 5'd0)) begin
            w_busy_next[mdu_dst] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    assign w_starve = (r_age >= AGE_MAX);

    assign stall = r_busy[rd_a1] | r_busy[rd_a2] | r_busy[rd_a3] | w_starve;

    // FIFO payload needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a3[r_wr_ptr] <= mdu_a3;
            r_fifo_wd[r_wr_ptr] <= mdu_wd;
            r_fifo_pc[r_wr_ptr] <= mdu_pc;
        end
    end

    // FIFO pointers and occupancy. Push and pop on the same edge leave the
    // count unchanged; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Count the cycles the head sits in the FIFO without draining. It
    // restarts whenever the head moves or the FIFO is empty, and saturates
    // so the stall stays asserted until the pipeline yields a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_age <= '0;
        end else if (!w_fifo_nonempty || w_pop) begin
            r_age <= '0;
        end else if (r_age != AGE_MAX) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Register scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Registered write port. Address, data and PC hold their last values
    // on idle cycles; only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grf_we <= 1'b0;
            r_grf_a3 <= 5'd0;
            r_grf_wd <= 32'd0;
            r_grf_pc <= 32'd0;
        end else begin
            r_grf_we <= w_grant;
            if (w_grant) begin
                r_grf_a3 <= w_next_a3;
                r_grf_wd <= w_next_wd;
                r_grf_pc <= w_next_pc;
            end
        end
    end

    assign grf_we = r_grf_we;
    assign grf_a3 = r_grf_a3;
    assign grf_wd = r_grf_wd;
    assign grf_pc = r_grf_pc;

`ifdef GRF_ARB_TRACE_EN
    // Trace each write on the edge where it is granted.
    always_ff @(posedge clk) begin
        if (!reset && w_grant) begin
            $display("%0t@%h: $%0d <= %h", $time, w_next_pc, w_next_a3, w_next_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for grf_wr_arbiter. Expected register-file writes are queued as
// the stimulus that causes them is driven; a negedge monitor pops and
// compares every write the DUT produces. Stall/ready/port values are also
// checked at fixed points of a directed sequence.
// ---------------------------------------------------------------------------
module tb_grf_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        mdu_issue;
    logic [4:0]  mdu_dst;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic [4:0]  rd_a3;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_t;

    wr_t expQ[$];
    wr_t monEntry;
    int  checks = 0;
    int  errors = 0;

    grf_wr_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_a3   (pipe_a3),
        .pipe_wd   (pipe_wd),
        .pipe_pc   (pipe_pc),
        .mdu_issue (mdu_issue),
        .mdu_dst   (mdu_dst),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_a3    (mdu_a3),
        .mdu_wd    (mdu_wd),
        .mdu_pc    (mdu_pc),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .rd_a3     (rd_a3),
        .stall     (stall),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue a write the DUT is expected to perform, in grant order.
    task automatic expectWrite(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        wr_t e;
        e.a3 = a3;
        e.wd = wd;
        e.pc = pc;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: every granted write must match the queue head.
    always @(negedge clk) begin
        if (grf_we === 1'b1) begin
            checkOutput("sb_write_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                monEntry = expQ.pop_front();
                checkOutput("sb_a3", 32'(grf_a3), 32'(monEntry.a3));
                checkOutput("sb_wd", grf_wd, monEntry.wd);
                checkOutput("sb_pc", grf_pc, monEntry.pc);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        pipe_we   = 1'b0;
        pipe_a3   = 5'd0;
        pipe_wd   = 32'd0;
        pipe_pc   = 32'd0;
        mdu_issue = 1'b0;
        mdu_dst   = 5'd0;
        mdu_valid = 1'b0;
        mdu_a3    = 5'd0;
        mdu_wd    = 32'd0;
        mdu_pc    = 32'd0;
        rd_a1     = 5'd0;
        rd_a2     = 5'd0;
        rd_a3     = 5'd0;

        // Reset state
        applyStimulus(2);
        reset = 1'b0;
        checkOutput("rst_ready", 32'(mdu_ready), 32'd1);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_we", 32'(grf_we), 32'd0);

        // Pipe-only write appears one cycle later
        pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h1234_5678; pipe_pc = 32'h100;
        expectWrite(5'd5, 32'h1234_5678, 32'h100);
        applyStimulus(1);
        checkOutput("pipe_we", 32'(grf_we), 32'd1);
        checkOutput("pipe_a3", 32'(grf_a3), 32'd5);
        checkOutput("pipe_wd", grf_wd, 32'h1234_5678);

        // A pipe write to $0 is not a write; address/data hold
        pipe_a3 = 5'd0; pipe_wd = 32'hDEAD_BEEF;
        applyStimulus(1);
        pipe_we = 1'b0;
        checkOutput("zero_we", 32'(grf_we), 32'd0);
        checkOutput("hold_a3", 32'(grf_a3), 32'd5);
        checkOutput("hold_wd", grf_wd, 32'h1234_5678);

        // Scoreboard and MDU drain for $8
        mdu_issue = 1'b1; mdu_dst = 5'd8;
        applyStimulus(1);
        mdu_issue = 1'b0;
        rd_a1 = 5'd8;
        #1;
        checkOutput("busy8_stall", 32'(stall), 32'd1);
        mdu_valid = 1'b1; mdu_a3 = 5'd8; mdu_wd = 32'hA; mdu_pc = 32'h200;
        expectWrite(5'd8, 32'hA, 32'h200);
        applyStimulus(1);
        mdu_valid = 1'b0;
        checkOutput("drain_wait_we", 32'(grf_we), 32'd0);
        checkOutput("drain_wait_stall", 32'(stall), 32'd1);
        applyStimulus(1);
        checkOutput("drain_we", 32'(grf_we), 32'd1);
        checkOutput("drain_a3", 32'(grf_a3), 32'd8);
        checkOutput("drain_wd", grf_wd, 32'hA);
        checkOutput("busy8_cleared", 32'(stall), 32'd0);
        rd_a1 = 5'd0;
        #1;
        checkOutput("rd0_stall", 32'(stall), 32'd0);

        // Same-edge set and clear on $4: the set must win
        mdu_issue = 1'b1; mdu_dst = 5'd4;
        applyStimulus(1);
        mdu_issue = 1'b0;
        mdu_valid = 1'b1; mdu_a3 = 5'd4; mdu_wd = 32'h44; mdu_pc = 32'h300;
        expectWrite(5'd4, 32'h44, 32'h300);
        applyStimulus(1);
        mdu_valid = 1'b0;
        mdu_issue = 1'b1; mdu_dst = 5'd4;
        applyStimulus(1);
        mdu_issue = 1'b0;
        rd_a2 = 5'd4;
        #1;
        checkOutput("setclr_a3", 32'(grf_a3), 32'd4);
        checkOutput("setclr_busy4", 32'(stall), 32'd1);
        mdu_valid = 1'b1; mdu_a3 = 5'd4; mdu_wd = 32'h45; mdu_pc = 32'h304;
        expectWrite(5'd4, 32'h45, 32'h304);
        applyStimulus(1);
        mdu_valid = 1'b0;
        applyStimulus(1);
        checkOutput("busy4_cleared", 32'(stall), 32'd0);
        rd_a2 = 5'd0;

        // Conflict: pipe writes $3 each cycle while two MDU results queue up
        for (int i = 0; i < 6; i++) begin
            pipe_we = 1'b1; pipe_a3 = 5'd3;
            pipe_wd = 32'h3000 + 32'(i); pipe_pc = 32'h400 + 32'(4 * i);
            expectWrite(5'd3, 32'h3000 + 32'(i), 32'h400 + 32'(4 * i));
            mdu_valid = (i < 2);
            mdu_a3 = 5'(10 + i); mdu_wd = 32'hB0 + 32'(i); mdu_pc = 32'h500 + 32'(4 * i);
            #1;
            checkOutput($sformatf("conflict_ready_%0d", i), 32'(mdu_ready), 32'(i < 2));
            checkOutput($sformatf("conflict_stall_%0d", i), 32'(stall), 32'(i >= 5));
            applyStimulus(1);
        end
        pipe_we = 1'b0; mdu_valid = 1'b0;
        expectWrite(5'd10, 32'hB0, 32'h500);
        expectWrite(5'd11, 32'hB1, 32'h504);
        #1;
        checkOutput("starve_stall", 32'(stall), 32'd1);
        applyStimulus(1);
        checkOutput("conf_drain1_a3", 32'(grf_a3), 32'd10);
        checkOutput("conf_drain1_stall", 32'(stall), 32'd0);
        checkOutput("conf_drain1_ready", 32'(mdu_ready), 32'd1);
        applyStimulus(1);
        checkOutput("conf_drain2_a3", 32'(grf_a3), 32'd11);
        applyStimulus(1);
        checkOutput("conf_idle_we", 32'(grf_we), 32'd0);

        // Reset with FIFO full and $7 busy
        mdu_issue = 1'b1; mdu_dst = 5'd7;
        pipe_we = 1'b1; pipe_a3 = 5'd3; pipe_wd = 32'h5000; pipe_pc = 32'h600;
        expectWrite(5'd3, 32'h5000, 32'h600);
        applyStimulus(1);
        mdu_issue = 1'b0;
        pipe_wd = 32'h5001; pipe_pc = 32'h604;
        expectWrite(5'd3, 32'h5001, 32'h604);
        mdu_valid = 1'b1; mdu_a3 = 5'd7; mdu_wd = 32'h70; mdu_pc = 32'h700;
        applyStimulus(1);
        pipe_wd = 32'h5002; pipe_pc = 32'h608;
        expectWrite(5'd3, 32'h5002, 32'h608);
        mdu_a3 = 5'd12; mdu_wd = 32'h71; mdu_pc = 32'h704;
        applyStimulus(1);
        mdu_valid = 1'b0; pipe_we = 1'b0;
        rd_a3 = 5'd7;
        #1;
        checkOutput("full_ready", 32'(mdu_ready), 32'd0);
        checkOutput("full_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("rst2_ready", 32'(mdu_ready), 32'd1);
        checkOutput("rst2_stall", 32'(stall), 32'd0);
        checkOutput("rst2_we", 32'(grf_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("rst2_no_stale_%0d", i), 32'(grf_we), 32'd0);
        end
        rd_a3 = 5'd0;

        applyStimulus(2);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wr_arbiter.md
GRF_WR_ARBITER -- requirements
Module: grf_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of cycles a buffered MDU result may wait before the block forces a pipeline stall.
REQ-002 SHALL have the ports below, in this order.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  W-stage write request; always accepted, never back-pressured.
- pipe_a3  in  5  W-stage destination register.
- pipe_wd  in  32  W-stage write data.
- pipe_pc  in  32  W-stage instruction PC.
- mdu_issue  in  1  an MDU op writing a GPR leaves D this cycle.
- mdu_dst  in  5  destination register of the issued MDU op.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  MDU result accepted on this edge when mdu_valid is also high.
- mdu_a3  in  5  MDU result destination register.
- mdu_wd  in  32  MDU result data.
- mdu_pc  in  32  MDU result PC.
- rd_a1, rd_a2, rd_a3  in  5 each  D-stage source and destination registers.
- stall  out  1  freeze F/D and inject a bubble.
- grf_we  out  1  register-file write enable.
- grf_a3  out  5  register-file write address.
- grf_wd  out  32  register-file write data.
- grf_pc  out  32  PC of the write, for tracing.

Function
REQ-003 SHALL treat a pipe write as present only when pipe_we=1 and pipe_a3!=0.
REQ-004 SHALL register grf_we/a3/wd/pc: the grant decided in cycle N appears in cycle N+1 (1-cycle latency).
REQ-005 SHALL give priority to a present pipe write: grf_* = pipe_* in the next cycle.
REQ-006 SHALL hold MDU results in a 2-entry FIFO; push on mdu_valid&&mdu_ready.
REQ-007 SHALL drive mdu_ready = (FIFO count<2), from state only, with no dependence on mdu_valid.
REQ-008 SHALL pop the FIFO head when count>0 and no pipe write is present; grf_* = head entry in the next cycle.
REQ-009 SHALL allow push and pop on the same edge with count unchanged; a push while full is impossible because ready is low.
REQ-010 SHALL drive grf_we=0 in the next cycle when neither a pipe write nor a pop occurs; grf_a3/wd/pc hold their previous values.
REQ-011 SHALL keep a busy bit per register 1..31; busy[0] is permanently 0.
REQ-012 SHALL set busy[mdu_dst] on mdu_issue when mdu_dst!=0.
REQ-013 SHALL clear busy[head.a3] on the edge where the head is popped; if a set and a clear hit the same register on the same edge, the set wins.
REQ-014 SHALL keep an age counter of cycles in which the head is present but not popped; the counter resets to 0 on pop or when the FIFO is empty.
REQ-015 SHALL compute starve = (age >= STARVE_LIMIT).
REQ-016 SHALL drive stall combinationally = busy[rd_a1] | busy[rd_a2] | busy[rd_a3] | starve.

Reset
REQ-017 SHALL, on reset, clear all of the following on the same edge: FIFO count, age counter, busy bits, grf_we/a3/wd/pc.
REQ-018 SHALL, on reset, make mdu_ready=1 and stall=0 in the following cycle; results in flight when reset is asserted are discarded.

Configuration
REQ-019 SHALL, with GRF_ARB_TRACE_EN defined, print "<time>@<grf_pc hex>: $<grf_a3 decimal> <= <grf_wd hex>" on every edge where a write is granted; without the macro, no simulation output.

Verification
REQ-020 Pipe only: pipe_we=1, a3=5, wd=0x12345678 -> next cycle grf_we=1, a3=5, wd=0x12345678.
REQ-021 MDU drain: idle pipe, mdu_valid with a3=8, wd=0xA -> grf_we=1, a3=8, wd=0xA two cycles after the push edge; busy[8] cleared on the pop edge.
REQ-022 Conflict: pipe writes $3 every cycle while two MDU results are pushed -> mdu_ready=0 after the 2nd push; stall=1 after 4 waiting cycles; MDU results written once pipe_we drops.
REQ-023 Scoreboard: mdu_issue with dst=9, then rd_a1=9 -> stall=1 until the $9 result is popped, 0 on the pop edge; rd_a1=0 never stalls.
REQ-024 Same-edge set/clear: pop of $4 while mdu_issue dst=4 -> busy[4] remains 1.
REQ-025 Reset with FIFO full and busy[7]=1 -> next cycle mdu_ready=1, stall=0, grf_we=0, no stale write afterwards.
